// File: rtl/cmp_seq_ctrl.sv
// Sequences one shared 8-bit cascadable comparator over WORDS bytes, LSB first,
// feeding each byte's lt/et/gt back as the cascade input of the next byte.
module cmp_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [8*WORDS-1:0] op_a,
    input  logic [8*WORDS-1:0] op_b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic               lt,
    output logic               et,
    output logic               gt,
    output logic               err,
    output logic [7:0]         cmp_a,
    output logic [7:0]         cmp_b,
    output logic               cmp_l,
    output logic               cmp_e,
    output logic               cmp_g,
    input  logic               cmp_lt,
    input  logic               cmp_et,
    input  logic               cmp_gt
);

    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [8*WORDS-1:0] a_q, b_q;
    logic               sgn_q;
    logic [IW-1:0]      idx;
    logic [2:0]         casc;
    logic [2:0]         res;
    logic               err_q;

    logic               accept;
    logic               last;
    logic [2:0]         cmp_res;
    logic               onehot;
    logic [7:0]         byte_a, byte_b;
    logic [7:0]         msb_flip;

    always_comb begin
        accept   = start && (state != RUN);
        last     = (idx == LAST);
        cmp_res  = {cmp_lt, cmp_et, cmp_gt};
        onehot   = (cmp_res == 3'b100) || (cmp_res == 3'b010) || (cmp_res == 3'b001);
        byte_a   = a_q[{idx, 3'b000} +: 8];
        byte_b   = b_q[{idx, 3'b000} +: 8];
        // Offset-binary on the MSB byte turns a signed compare into an unsigned one.
        msb_flip = {sgn_q & last, 7'b0};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == RUN);
        done  = (state == DONE);
        cmp_a = '0;
        cmp_b = '0;
        if (state == RUN) begin
            cmp_a = byte_a ^ msb_flip;
            cmp_b = byte_b ^ msb_flip;
        end
        {cmp_l, cmp_e, cmp_g} = casc;
        {lt, et, gt}          = res;
        err                   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            idx   <= '0;
            casc  <= 3'b010;
            res   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= op_a;
                b_q   <= op_b;
                sgn_q <= signed_mode;
                idx   <= '0;
                casc  <= 3'b010;
                res   <= '0;
                err_q <= 1'b0;
            end else if (state == RUN) begin
                casc <= cmp_res;
                if (!onehot) err_q <= 1'b1;
                if (last) res <= cmp_res;
                else      idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Scoreboard bench for cmp_seq_ctrl: a behavioural comparator model closes the loop,
// a driver queues expected results and a monitor checks them on each done pulse.
module tb_cmp_seq_ctrl;

    localparam int WORDS = 4;
    localparam int OW    = 8 * WORDS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [OW-1:0] op_a = '0;
    logic [OW-1:0] op_b = '0;
    logic          signed_mode = 1'b0;
    logic          busy, done, lt, et, gt, err;
    logic [7:0]    cmp_a, cmp_b;
    logic          cmp_l, cmp_e, cmp_g;
    logic          m_lt, m_et, m_gt;

    int cyc = 0;
    int fault_cyc = -1;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] rel;
        logic       err;
        int         c0;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    cmp_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .signed_mode(signed_mode), .busy(busy), .done(done), .lt(lt), .et(et),
        .gt(gt), .err(err), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_l(cmp_l),
        .cmp_e(cmp_e), .cmp_g(cmp_g), .cmp_lt(m_lt), .cmp_et(m_et), .cmp_gt(m_gt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cascadable 8-bit comparator; returns 000 in the cycle selected by fault_cyc.
    always_comb begin
        if (fault_cyc == cyc)   {m_lt, m_et, m_gt} = 3'b000;
        else if (cmp_a < cmp_b) {m_lt, m_et, m_gt} = 3'b100;
        else if (cmp_a > cmp_b) {m_lt, m_et, m_gt} = 3'b001;
        else                    {m_lt, m_et, m_gt} = {cmp_l, cmp_e, cmp_g};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Whole-word relation; with a fault at byte k only the bytes above k can decide.
    function automatic logic [2:0] ref_rel(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                           input logic s, input int k);
        logic [OW-1:0] ha, hb;
        if (k < 0) begin
            if (a == b) return 3'b010;
            if (s) return ($signed(a) < $signed(b)) ? 3'b100 : 3'b001;
            return (a < b) ? 3'b100 : 3'b001;
        end
        ha = a >> (8 * (k + 1));
        hb = b >> (8 * (k + 1));
        if (ha == hb) return 3'b000;
        return (ha < hb) ? 3'b100 : 3'b001;
    endfunction

    task automatic start_job(input logic [OW-1:0] a, input logic [OW-1:0] b,
                             input logic s, input int k);
        int t = 0;
        @(negedge clk);
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
        op_a = a;
        op_b = b;
        signed_mode = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        signed_mode = 1'($urandom_range(0, 1));
        if (k >= 0) fault_cyc = cyc + k;
        sbq.push_back('{rel: ref_rel(a, b, s, k), err: (k >= 0), c0: cyc});
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("rel", {lt, et, gt}, mon_e.rel);
                check("err", 32'(err), 32'(mon_e.err));
                check("latency", 32'(cyc - mon_e.c0), 32'(WORDS));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] a, b, tmp;
        logic          s;
        int            k, sel, j;

        repeat (2) @(negedge clk);
        check("rst_state", {busy, done, lt, et, gt, err}, 6'b0);
        check("rst_cmp", {cmp_a, cmp_b, cmp_l, cmp_e, cmp_g}, {16'h0, 3'b010});
        rst_n = 1'b1;

        // Small A below B: busy for WORDS cycles, done the cycle after.
        start_job(32'h0000_00D1, 32'h0000_00FF, 1'b0, -1);
        for (int i = 1; i <= WORDS; i++) begin
            @(negedge clk);
            check("busy_run", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);

        // Equal operands: cascade equal held throughout, result held afterwards.
        start_job(32'h1234_5678, 32'h1234_5678, 1'b0, -1);
        for (int i = 1; i <= WORDS; i++) begin
            @(negedge clk);
            check("casc_eq", 32'(cmp_e), 32'd1);
        end
        drain();
        repeat (3) begin
            @(negedge clk);
            check("hold_eq", {lt, et, gt}, 3'b010);
        end

        start_job(32'h0100_0000, 32'h00FF_FFFF, 1'b0, -1);

        // Signed: MSB byte bit 7 inverted on both sides.
        start_job(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, -1);
        for (int i = 1; i <= WORDS; i++) begin
            @(negedge clk);
            if (i == WORDS) begin
                check("msb_a", 32'(cmp_a), 32'h7F);
                check("msb_b", 32'(cmp_b), 32'h80);
            end
        end
        start_job(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1);

        // Start during RUN is ignored.
        start_job(32'h0000_0010, 32'h0000_0020, 1'b0, -1);
        @(negedge clk);
        @(negedge clk);
        op_a = 32'hFFFF_FFFF;
        op_b = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset in cycle 2 of the next job aborts it without a done pulse.
        start_job(32'h1122_3344, 32'h1122_3355, 1'b0, -1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_state", {busy, done, lt, et, gt, err}, 6'b0);
        check("abort_cmp", {cmp_a, cmp_b, cmp_l, cmp_e, cmp_g}, {16'h0, 3'b010});
        sbq.delete(sbq.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;
        start_job(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, -1);

        // Comparator fault at byte 1: err sticky until the next start.
        start_job(32'h55AA_0000, 32'h55AA_0000, 1'b0, 1);
        drain();
        repeat (2) begin
            @(negedge clk);
            check("err_hold", 32'(err), 32'd1);
        end
        start_job(32'h0000_0001, 32'h0000_0002, 1'b0, -1);
        @(negedge clk);
        check("err_clear", 32'(err), 32'd0);

        // Randomised back-to-back jobs.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            sel = $urandom_range(0, 2);
            if (sel == 0) b = $urandom;
            else if (sel == 1) b = a;
            else begin
                tmp = a;
                j = $urandom_range(0, WORDS - 1);
                tmp[8 * j +: 8] = 8'($urandom);
                b = tmp;
            end
            s = 1'($urandom_range(0, 1));
            k = (!s && $urandom_range(0, 5) == 0) ? $urandom_range(0, WORDS - 1) : -1;
            start_job(a, b, s, k);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
